// File: rtl/sap_step_sequencer.sv
// SAP-1 microprogram sequencer: six-state T ring with opcode decode to the
// 12-bit control word, plus run/single-step control, halt and retire counting.
module sap_step_sequencer #(
    parameter int          CNT_W    = 8,
    parameter logic [11:0] IDLE_CON = 12'h3E3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [3:0]       opcode,
    input  logic             step_mode,
    input  logic             step_req,
    output logic [11:0]      con,
    output logic [5:0]       t_state,
    output logic             halted,
    output logic             step_ack,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        S_WAIT, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t state, state_nxt;
    logic   from_step;

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= S_WAIT;
            step_ack    <= 1'b0;
            instr_count <= '0;
            from_step   <= 1'b0;
        end else begin
            state    <= state_nxt;
            step_ack <= (state == S_T6) && from_step;
            if (state == S_T6)
                instr_count <= instr_count + 1'b1;
            // Remember whether this instruction was launched by a step request
            if (state == S_WAIT && state_nxt == S_T1)
                from_step <= step_req;
            else if (state == S_T6)
                from_step <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        con       = IDLE_CON;
        t_state   = 6'b000000;
        halted    = 1'b0;
        case (state)
            S_WAIT: begin
                if (!step_mode || step_req)
                    state_nxt = S_T1;
            end
            S_T1: begin
                t_state   = 6'b000001;
                con       = 12'h5E3;
                state_nxt = S_T2;
            end
            S_T2: begin
                t_state   = 6'b000010;
                con       = 12'hBE3;
                state_nxt = S_T3;
            end
            S_T3: begin
                t_state   = 6'b000100;
                con       = 12'h263;
                state_nxt = S_T4;
            end
            S_T4: begin
                t_state = 6'b001000;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: con = 12'h1A3;
                    OP_OUT:                 con = 12'h3F2;
                    default:                con = IDLE_CON;
                endcase
                state_nxt = (opcode == OP_HLT) ? S_HALT : S_T5;
            end
            S_T5: begin
                t_state = 6'b010000;
                case (opcode)
                    OP_LDA:         con = 12'h2C3;
                    OP_ADD, OP_SUB: con = 12'h2E1;
                    default:        con = IDLE_CON;
                endcase
                state_nxt = S_T6;
            end
            S_T6: begin
                t_state = 6'b100000;
                case (opcode)
                    OP_ADD:  con = 12'h3C7;
                    OP_SUB:  con = 12'h3CF;
                    default: con = IDLE_CON;
                endcase
                state_nxt = step_mode ? S_WAIT : S_T1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_sap_step_sequencer.sv
// Scoreboard bench for sap_step_sequencer: a phase-level reference model pushes
// expected outputs per edge; a monitor pops and compares after every rising edge.
module tb_sap_step_sequencer;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             clr;
    logic [3:0]       opcode;
    logic             step_mode;
    logic             step_req;
    logic [11:0]      con;
    logic [5:0]       t_state;
    logic             halted;
    logic             step_ack;
    logic [CNT_W-1:0] instr_count;

    sap_step_sequencer #(.CNT_W(CNT_W), .IDLE_CON(12'h3E3)) dut (
        .clk(clk), .clr(clr), .opcode(opcode), .step_mode(step_mode),
        .step_req(step_req), .con(con), .t_state(t_state), .halted(halted),
        .step_ack(step_ack), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Small SAP-1 datapath driven by the control word; supplies the opcode in program mode
    logic       dp_mode = 1'b0;
    logic [3:0] op_drv  = 4'h0;
    logic [7:0] ram [16];
    logic [3:0] pc, mar;
    logic [7:0] ir, acc, breg, out_reg, wbus;

    assign opcode = dp_mode ? ir[7:4] : op_drv;

    always_comb begin
        wbus = 8'h00;
        if (con[10])      wbus = {4'h0, pc};
        else if (!con[8]) wbus = ram[mar];
        else if (!con[6]) wbus = {4'h0, ir[3:0]};
        else if (con[4])  wbus = acc;
        else if (con[2])  wbus = con[3] ? acc - breg : acc + breg;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pc <= 4'h0; mar <= 4'h0; ir <= 8'h00;
            acc <= 8'h00; breg <= 8'h00; out_reg <= 8'h00;
        end else begin
            if (con[11]) pc <= pc + 4'h1;
            if (!con[9]) mar <= wbus[3:0];
            if (!con[7]) ir <= wbus;
            if (!con[5]) acc <= wbus;
            if (!con[1]) breg <= wbus;
            if (!con[0]) out_reg <= wbus;
        end
    end

    // Reference model: phase 0 = WAIT, 1..6 = T1..T6, 7 = HALTED
    typedef struct { int phase; int cnt; bit ack; } exp_t;
    exp_t exp_q[$];
    int m_phase = 0;
    int m_cnt   = 0;
    bit m_ack   = 0;
    bit m_fs    = 0;

    function automatic logic [11:0] con_of(input int ph, input logic [3:0] op);
        case (ph)
            1: return 12'h5E3;
            2: return 12'hBE3;
            3: return 12'h263;
            4: return (op <= 4'h2) ? 12'h1A3 : (op == 4'hE) ? 12'h3F2 : 12'h3E3;
            5: return (op == 4'h0) ? 12'h2C3 : (op == 4'h1 || op == 4'h2) ? 12'h2E1 : 12'h3E3;
            6: return (op == 4'h1) ? 12'h3C7 : (op == 4'h2) ? 12'h3CF : 12'h3E3;
            default: return 12'h3E3;
        endcase
    endfunction

    function automatic void model_step(input bit c, input bit m, input bit r, input logic [3:0] op);
        if (c) begin
            m_phase = 0; m_cnt = 0; m_ack = 0; m_fs = 0;
            return;
        end
        m_ack = 0;
        if (m_phase == 0) begin
            if (!m || r) begin m_fs = r; m_phase = 1; end
        end else if (m_phase >= 1 && m_phase <= 3) begin
            m_phase = m_phase + 1;
        end else if (m_phase == 4) begin
            m_phase = (op == 4'hF) ? 7 : 5;
        end else if (m_phase == 5) begin
            m_phase = 6;
        end else if (m_phase == 6) begin
            m_cnt   = (m_cnt + 1) % (1 << CNT_W);
            m_ack   = m_fs;
            m_fs    = 0;
            m_phase = m ? 0 : 1;
        end
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cycle(input bit c, input bit m, input bit r, input logic [3:0] op);
        exp_t e;
        logic [3:0] op_eff;
        @(negedge clk);
        clr = c; step_mode = m; step_req = r; op_drv = op;
        op_eff = dp_mode ? ir[7:4] : op;
        model_step(c, m, r, op_eff);
        e.phase = m_phase; e.cnt = m_cnt; e.ack = m_ack;
        exp_q.push_back(e);
    endtask

    // Monitor
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("con", int'(con), int'(con_of(e.phase, opcode)));
            chk("t_state", int'(t_state), (e.phase >= 1 && e.phase <= 6) ? (1 << (e.phase - 1)) : 0);
            chk("halted", int'(halted), (e.phase == 7) ? 1 : 0);
            chk("step_ack", int'(step_ack), int'(e.ack));
            chk("instr_count", int'(instr_count), e.cnt);
        end
    end

    initial begin
        int guard;
        bit rm, rr;
        logic [3:0] ro;
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        ram[0] = 8'h09; ram[1] = 8'h1A; ram[2] = 8'h2B; ram[3] = 8'hE0; ram[4] = 8'hF0;
        ram[9] = 8'h10; ram[10] = 8'h14; ram[11] = 8'h04;
        clr = 1'b1; step_mode = 1'b0; step_req = 1'b0;

        // Free-run program from RAM
        dp_mode = 1'b1;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        guard = 0;
        while (m_phase != 7 && guard < 80) begin
            cycle(0, 0, 0, 0);
            guard++;
        end
        chk("program_halt_bound", guard < 80 ? 1 : 0, 1);
        cycle(0, 0, 0, 0);
        chk("out_reg", int'(out_reg), 32'h20);

        // HALTED ignores step inputs
        for (int i = 0; i < 20; i++) cycle(0, 1'($urandom), 1'($urandom), 0);
        cycle(1, 1, 0, 0);
        dp_mode = 1'b0;

        // Single pulse in step mode
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 4'h0);
        cycle(0, 1, 1, 4'h0);
        for (int i = 0; i < 12; i++) cycle(0, 1, 0, 4'h0);

        // Held request: three instructions
        cycle(1, 1, 0, 4'h1);
        for (int i = 0; i < 21; i++) cycle(0, 1, 1, 4'h1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 4'h1);

        // Reset during T5 of ADD, then resume
        cycle(1, 0, 0, 4'h1);
        guard = 0;
        while (m_phase != 5 && guard < 20) begin
            cycle(0, 0, 0, 4'h1);
            guard++;
        end
        cycle(1, 0, 0, 4'h1);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 4'h1);

        // Undefined opcode counted, counter wraps
        cycle(1, 0, 0, 4'h5);
        for (int i = 0; i < 257 * 6 + 2; i++) cycle(0, 0, 0, 4'h5);

        // Randomized run
        rm = 0; rr = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) rm = 1'($urandom);
            rr = ($urandom_range(0, 3) == 0);
            ro = ($urandom_range(0, 49) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            if ((m_phase == 7 && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0)
                cycle(1, rm, rr, ro);
            else
                cycle(0, rm, rr, ro);
        end

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
